// File: rtl/gray_pkg.sv
// Shared constants and Gray-code helpers for the Gray-code datapath.
// Consumers on the far side of a clock crossing use gray2bin to recover the count.
package gray_pkg;

    localparam int GRAY_WIDTH = 8;

    function automatic logic [GRAY_WIDTH-1:0] bin2gray(input logic [GRAY_WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Each binary bit is the XOR of all Gray bits at or above it, so decode runs MSB down.
    function automatic logic [GRAY_WIDTH-1:0] gray2bin(input logic [GRAY_WIDTH-1:0] g);
        logic [GRAY_WIDTH-1:0] b;
        b[GRAY_WIDTH-1] = g[GRAY_WIDTH-1];
        for (int i = GRAY_WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/bin2gray_enc.sv
// Combinational binary-to-Gray encoder.
// The MSB passes through unchanged, and every lower bit is the XOR of itself with its upper neighbour.
module bin2gray_enc #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray
);

    assign gray = bin ^ (bin >> 1);

endmodule

// File: rtl/gray_code_counter.sv
// Up/down binary counter with parallel load that registers its Gray code alongside the count.
// Because both outputs come from one register stage, gray_out is safe to use as a clock-crossing pointer.
module gray_code_counter
    import gray_pkg::*;
#(
    parameter int WIDTH = GRAY_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             ld,
    input  logic [WIDTH-1:0] ld_bin,
    output logic [WIDTH-1:0] bin_out,
    output logic [WIDTH-1:0] gray_out,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
    localparam logic [WIDTH-1:0] ALL_ONES = '1;

    logic [WIDTH-1:0] next_bin;
    logic [WIDTH-1:0] next_gray;
    logic             next_wrap;

    always_comb begin
        next_bin  = bin_out;
        next_wrap = 1'b0;
        if (ld) begin
            next_bin = ld_bin;
        end else if (en) begin
            if (up) begin
                next_bin  = bin_out + ONE;
                next_wrap = (bin_out == ALL_ONES);
            end else begin
                next_bin  = bin_out - ONE;
                next_wrap = (bin_out == '0);
            end
        end
    end

    // Encode the next value so that gray_out lands in the same register stage as bin_out.
    bin2gray_enc #(.WIDTH(WIDTH)) u_enc (
        .bin  (next_bin),
        .gray (next_gray)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            bin_out  <= '0;
            gray_out <= '0;
            wrap     <= 1'b0;
        end else begin
            bin_out  <= next_bin;
            gray_out <= next_gray;
            wrap     <= next_wrap;
        end
    end

    assign tc = (up & (bin_out == ALL_ONES)) | (~up & (bin_out == '0));

    a_gray_matches_bin : assert property (@(posedge clk) disable iff (rst)
        gray_out == (bin_out ^ (bin_out >> 1)));

    a_single_bit_step : assert property (@(posedge clk)
        (!rst && !ld && en) |=> ($countones(gray_out ^ $past(gray_out)) == 1));

endmodule

// File: tb/tb_gray_code_counter.sv
// Scoreboard bench for gray_code_counter: stimulus pushes hand-computed or modelled expectations,
// and a monitor compares them against the DUT one cycle later, including the single-bit Gray rule.
module tb_gray_code_counter;
    import gray_pkg::*;

    typedef struct {
        logic [7:0] bin;
        logic [7:0] gray;
        logic       wrap;
        logic       tc;
        logic       step;
        logic       chk_gray;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       en;
    logic       up;
    logic       ld;
    logic [7:0] ld_bin;
    logic [7:0] bin_out;
    logic [7:0] gray_out;
    logic       tc;
    logic       wrap;

    exp_t       sb[$];
    int         n_tests;
    int         n_fail;
    logic [7:0] prev_gray;
    logic [7:0] model_bin;

    gray_code_counter #(.WIDTH(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .up       (up),
        .ld       (ld),
        .ld_bin   (ld_bin),
        .bin_out  (bin_out),
        .gray_out (gray_out),
        .tc       (tc),
        .wrap     (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic compare(input string name, input logic [7:0] act, input logic [7:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic l, input logic [7:0] lb,
                                 input logic e, input logic u,
                                 input logic [7:0] exp_bin, input logic [7:0] exp_gray,
                                 input logic exp_wrap, input logic exp_tc, input logic chk_gray);
        exp_t x;
        @(negedge clk);
        rst    = r;
        ld     = l;
        ld_bin = lb;
        en     = e;
        up     = u;
        x.bin      = exp_bin;
        x.gray     = exp_gray;
        x.wrap     = exp_wrap;
        x.tc       = exp_tc;
        x.step     = !r && !l && e;
        x.chk_gray = chk_gray;
        sb.push_back(x);
    endtask

    // Independent next-state model for the long en/up sequence.
    task automatic modelStep(input logic e, input logic u);
        logic       w;
        logic       t;
        w = 1'b0;
        if (e) begin
            if (u) begin
                w = (model_bin == 8'hFF);
                model_bin = model_bin + 8'd1;
            end else begin
                w = (model_bin == 8'h00);
                model_bin = model_bin - 8'd1;
            end
        end
        t = (u && model_bin == 8'hFF) || (!u && model_bin == 8'h00);
        applyStimulus(1'b0, 1'b0, 8'h00, e, u, model_bin, 8'h00, w, t, 1'b0);
    endtask

    task automatic checkOutput(input exp_t x);
        compare("bin_out", bin_out, x.bin);
        compare("wrap", {7'd0, wrap}, {7'd0, x.wrap});
        compare("tc", {7'd0, tc}, {7'd0, x.tc});
        compare("gray2bin(gray_out)", gray2bin(gray_out), x.bin);
        if (x.chk_gray) compare("gray_out", gray_out, x.gray);
        if (x.step) compare("gray_step_bits", 8'($countones(gray_out ^ prev_gray)), 8'd1);
        prev_gray = gray_out;
    endtask

    initial begin : monitor
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) checkOutput(sb.pop_front());
        end
    end

    initial begin : stimulus
        n_tests   = 0;
        n_fail    = 0;
        prev_gray = 8'h00;
        rst = 1'b1; ld = 1'b0; ld_bin = 8'h00; en = 1'b0; up = 1'b1;

        // rst  ld  ld_bin  en  up    bin    gray   wrap  tc
        applyStimulus(1, 0, 8'h00, 0, 1, 8'h00, 8'h00, 0, 0, 1);
        applyStimulus(0, 0, 8'h00, 1, 1, 8'h01, 8'h01, 0, 0, 1);
        applyStimulus(0, 0, 8'h00, 1, 1, 8'h02, 8'h03, 0, 0, 1);
        applyStimulus(0, 0, 8'h00, 1, 1, 8'h03, 8'h02, 0, 0, 1);
        applyStimulus(0, 0, 8'h00, 1, 1, 8'h04, 8'h06, 0, 0, 1);
        applyStimulus(0, 1, 8'hBB, 0, 1, 8'hBB, 8'hE6, 0, 0, 1);
        applyStimulus(0, 1, 8'hFF, 0, 1, 8'hFF, 8'h80, 0, 1, 1);
        applyStimulus(0, 0, 8'h00, 1, 1, 8'h00, 8'h00, 1, 0, 1);
        applyStimulus(0, 0, 8'h00, 0, 1, 8'h00, 8'h00, 0, 0, 1);
        applyStimulus(1, 0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 1, 1);
        applyStimulus(0, 0, 8'h00, 1, 0, 8'hFF, 8'h80, 1, 0, 1);
        applyStimulus(0, 0, 8'h00, 1, 0, 8'hFE, 8'h81, 0, 0, 1);
        applyStimulus(0, 0, 8'h00, 1, 1, 8'hFF, 8'h80, 0, 1, 1);
        applyStimulus(0, 0, 8'h00, 1, 0, 8'hFE, 8'h81, 0, 0, 1);
        applyStimulus(0, 1, 8'h10, 1, 1, 8'h10, 8'h18, 0, 0, 1);
        applyStimulus(1, 1, 8'hAA, 1, 1, 8'h00, 8'h00, 0, 0, 1);
        applyStimulus(0, 0, 8'h00, 1, 1, 8'h01, 8'h01, 0, 0, 1);

        model_bin = 8'h01;
        for (int i = 0; i < 2000; i++) begin
            modelStep(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
        end

        @(negedge clk);
        en = 1'b0;
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        #2;
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
